data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_defs.sv | 19 +
 rtl/wait_counter.sv | 31 +++
 rtl/data_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_defs.sv
// Shared definitions for the data-memory controller: FSM encoding,
// default timeout depth and the value returned on a timed-out access.
package data_mem_defs;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int          TIMEOUT_DEFAULT = 16;
   localparam logic [31:0] DEAD_BEEF       = 32'hDEAD_BEEF;

   // A data access is word-aligned when the two byte-offset bits are zero.
   function automatic logic is_aligned(input logic [1:0] byte_off);
      return (byte_off == 2'b00);
   endfunction

endpackage

// File: rtl/wait_counter.sv
// Saturating wait counter for the memory handshake. Counts enabled cycles
// from a synchronous clear and flags when it has reached TERMINAL.
module wait_counter #(
   parameter int TERMINAL = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int             CW   = (TERMINAL > 1) ? $clog2(TERMINAL + 1) : 1;
   localparam logic [CW-1:0]  TERM = CW'(TERMINAL);

   logic [CW-1:0] r_count;

   // Clear wins over enable; counting stops at TERM so the value never wraps.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_count <= '0;
      end else if (clr_i) begin
         r_count <= '0;
      end else if (en_i && (r_count != TERM)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign tc_o = (r_count == TERM);

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller between a single-issue CPU and a slow data memory.
// A load/store stalls the CPU while a registered request is held toward the
// memory; completion (ack or timeout) is followed by one DONE cycle in which
// the CPU is released and no new access may start.
module data_mem_ctrl
   import data_mem_defs::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        align_err_o,
   output logic        timeout_o
);

   state_t      r_state;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;
   logic        r_align_err;
   logic        r_timeout;

   logic        w_req;
   logic        w_aligned;
   logic        w_start;
   logic        w_in_access;
   logic        w_tc;

   assign w_req       = MemRead_i | MemWrite_i;
   assign w_aligned   = is_aligned(addr_i[1:0]);
   assign w_start     = (r_state == IDLE) && w_req && w_aligned;
   assign w_in_access = (r_state == ACCESS);

   // The stall must cover the request cycle itself, so it is decoded from the
   // live CPU request rather than registered; DONE releases the CPU.
   assign stall_o = w_start | w_in_access;

   // Counter is cleared on the edge that enters ACCESS and advances on every
   // ACCESS cycle that passes without an ack.
   wait_counter #(
      .TERMINAL (TIMEOUT - 1)
   ) u_wait_counter (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (w_start),
      .en_i  (w_in_access && !mem_ack_i),
      .tc_o  (w_tc)
   );

   // Controller FSM with all memory-side and CPU-side outputs registered.
   // NOTE: every assignment here is non-blocking so all registers update from
   // the same pre-edge values; a blocking write would leak into later reads.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_align_err <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_align_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  if (w_aligned) begin
                     r_mem_addr  <= addr_i;
                     r_mem_wdata <= wdata_i;
                     r_mem_we    <= MemWrite_i;
                     r_mem_req   <= 1'b1;
                     r_state     <= ACCESS;
                  end else begin
                     r_align_err <= 1'b1;
                     r_rdata     <= '0;
                  end
               end
            end
            ACCESS: begin
               if (mem_ack_i) begin
                  if (!r_mem_we) begin
                     r_rdata <= mem_rdata_i;
                  end
                  r_mem_req <= 1'b0;
                  r_state   <= DONE;
               end else if (w_tc) begin
                  r_timeout <= 1'b1;
                  r_rdata   <= DEAD_BEEF;
                  r_mem_req <= 1'b0;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_mem_req <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign rdata_o     = r_rdata;
   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign align_err_o = r_align_err;
   assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a CPU-side driver pushes the expected
// outcome of each instruction, a memory responder acks after a programmed
// number of ACCESS cycles, and a monitor compares on every completion.
module tb_data_mem_ctrl;

   logic        clk_i       = 1'b0;
   logic        rst_i       = 1'b0;
   logic [31:0] addr_i      = '0;
   logic [31:0] wdata_i     = '0;
   logic        MemRead_i   = 1'b0;
   logic        MemWrite_i  = 1'b0;
   logic        mem_ack_i   = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        align_err_o;
   logic        timeout_o;

   data_mem_ctrl #(
      .TIMEOUT (16)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .MemRead_i   (MemRead_i),
      .MemWrite_i  (MemWrite_i),
      .rdata_o     (rdata_o),
      .stall_o     (stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .align_err_o (align_err_o),
      .timeout_o   (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          tag;
      bit          is_align;
      logic [31:0] rdata;
      bit          timeout;
      int          stall;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Memory responder: acks in the ack_at-th ACCESS cycle (0 = never).
   // Outside the ack cycle the read bus carries junk that must be ignored.
   int          ack_at   = 0;
   logic [31:0] ack_data = '0;
   bit          late_ack = 1'b0;
   int          acc_cnt  = 0;

   always @(negedge clk_i) begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'h0BAD_F00D;
      if (mem_req_o) begin
         acc_cnt++;
         if (acc_cnt == ack_at) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = ack_data;
         end
      end else begin
         acc_cnt = 0;
      end
      if (late_ack) begin
         mem_ack_i   = 1'b1;
         mem_rdata_i = 32'h5555_AAAA;
      end
   end

   // Monitor: a completion is either an align_err pulse or the DONE cycle
   // (mem_req_o falling outside reset).
   bit          mon_prev_req = 1'b0;
   bit          mon_saw_req  = 1'b0;
   int          mon_stall    = 0;
   logic        mon_we;
   logic [31:0] mon_addr;
   logic [31:0] mon_wdata;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            mon_prev_req = 1'b0;
            mon_saw_req  = 1'b0;
            mon_stall    = 0;
            continue;
         end
         if (stall_o) mon_stall++;
         if (mem_req_o && !mon_prev_req) begin
            mon_saw_req = 1'b1;
            mon_we      = mem_we_o;
            mon_addr    = mem_addr_o;
            mon_wdata   = mem_wdata_o;
         end
         if (align_err_o || (mon_prev_req && !mem_req_o)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected completion: align_err=%b rdata=%h, expected no completion",
                        align_err_o, rdata_o);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("t%0d kind", e.tag), 32'(align_err_o), 32'(e.is_align));
               check($sformatf("t%0d rdata", e.tag), rdata_o, e.rdata);
               check($sformatf("t%0d timeout", e.tag), 32'(timeout_o), 32'(e.timeout));
               check($sformatf("t%0d stall cycles", e.tag), 32'(mon_stall), 32'(e.stall));
               if (e.is_align) begin
                  check($sformatf("t%0d no mem_req", e.tag), 32'(mon_saw_req), 32'd0);
               end else begin
                  check($sformatf("t%0d stall in DONE", e.tag), 32'(stall_o), 32'd0);
                  check($sformatf("t%0d mem_we", e.tag), 32'(mon_we), 32'(e.we));
                  check($sformatf("t%0d mem_addr", e.tag), mon_addr, e.addr);
                  if (e.we) check($sformatf("t%0d mem_wdata", e.tag), mon_wdata, e.wdata);
               end
            end
            mon_stall   = 0;
            mon_saw_req = 1'b0;
         end
         mon_prev_req = mem_req_o;
      end
   end

   // CPU driver: present one instruction at posedge+1 and hold it until the
   // controller releases the stall. Returns at posedge+1 of the next cycle.
   task automatic issue(input int tag, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_n, input logic [31:0] ad,
                        input logic [31:0] e_rdata, input bit e_to, input int e_stall);
      exp_t e;
      int   n    = 0;
      bit   done = 1'b0;
      e.tag      = tag;
      e.is_align = (a[1:0] != 2'b00);
      e.rdata    = e_rdata;
      e.timeout  = e_to;
      e.stall    = e_stall;
      e.we       = wr;
      e.addr     = a;
      e.wdata    = wd;
      exp_q.push_back(e);
      ack_at     = ack_n;
      ack_data   = ad;
      addr_i     = a;
      wdata_i    = wd;
      MemRead_i  = rd;
      MemWrite_i = wr;
      while (!done && n < 60) begin
         @(negedge clk_i);
         n++;
         if (!stall_o) done = 1'b1;
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL t%0d stall release: still stalled after %0d cycles, expected release", tag, n);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      MemRead_i  = 1'b0;
      MemWrite_i = 1'b0;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #2;
      check("reset rdata", rdata_o, 32'd0);
      check("reset mem_req", 32'(mem_req_o), 32'd0);
      check("reset stall", 32'(stall_o), 32'd0);
      check("reset timeout", 32'(timeout_o), 32'd0);
      check("reset mem_addr", mem_addr_o, 32'd0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      idle(1);

      //     tag rd wr addr          wdata         ack data            exp rdata     to stall
      issue(1,  1, 0, 32'h0000_0010, 32'h0,        1,  32'h1234_5678, 32'h1234_5678, 0, 2);
      idle(1);
      issue(2,  0, 1, 32'h0000_0020, 32'hCAFE_0001, 3, 32'hFFFF_FFFF, 32'h1234_5678, 0, 4);
      idle(1);
      issue(3,  1, 0, 32'h0000_0013, 32'h0,        0,  32'h0,         32'h0,         0, 0);
      idle(1);
      issue(4,  1, 1, 32'h0000_0024, 32'h55AA_55AA, 2, 32'h0F0F_0F0F, 32'h0,         0, 3);
      idle(2);
      issue(5,  1, 0, 32'h0000_0030, 32'h0,        5,  32'hA5A5_0F0F, 32'hA5A5_0F0F, 0, 6);
      // Same load twice with MemRead_i held through DONE: two bursts only.
      issue(6,  1, 0, 32'h0000_0040, 32'h0,        1,  32'h1111_1111, 32'h1111_1111, 0, 2);
      issue(7,  1, 0, 32'h0000_0040, 32'h0,        1,  32'h3333_3333, 32'h3333_3333, 0, 2);
      idle(1);
      // Ack in the very last allowed ACCESS cycle beats the timeout.
      issue(8,  1, 0, 32'h0000_0058, 32'h0,        16, 32'h1616_1616, 32'h1616_1616, 0, 17);
      idle(1);
      issue(9,  1, 0, 32'h0000_0050, 32'h0,        0,  32'h0,         32'hDEAD_BEEF, 1, 17);
      idle(1);
      issue(10, 1, 0, 32'h0000_0054, 32'h0,        1,  32'h7777_7777, 32'h7777_7777, 1, 2);
      idle(1);
      issue(11, 0, 1, 32'h0000_0062, 32'h1,        0,  32'h0,         32'h0,         1, 0);
      idle(1);
      issue(12, 0, 1, 32'h0000_0064, 32'hBEEF_0064, 1, 32'h0,        32'h0,         1, 2);
      idle(2);

      // Reset in the middle of an access, then a stray ack after release.
      ack_at    = 0;
      addr_i    = 32'h0000_0070;
      MemRead_i = 1'b1;
      n = 0;
      while (!mem_req_o && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      check("reset test reached ACCESS", 32'(mem_req_o), 32'd1);
      @(posedge clk_i);
      #1;
      rst_i     = 1'b0;
      MemRead_i = 1'b0;
      #1;
      check("mid-access reset mem_req", 32'(mem_req_o), 32'd0);
      check("mid-access reset mem_addr", mem_addr_o, 32'd0);
      check("mid-access reset rdata", rdata_o, 32'd0);
      check("mid-access reset timeout", 32'(timeout_o), 32'd0);
      check("mid-access reset stall", 32'(stall_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      late_ack = 1'b1;
      @(posedge clk_i);
      #1;
      late_ack = 1'b0;
      repeat (2) begin
         @(negedge clk_i);
         check("late ack mem_req", 32'(mem_req_o), 32'd0);
         check("late ack rdata", rdata_o, 32'd0);
         check("late ack stall", 32'(stall_o), 32'd0);
      end
      @(posedge clk_i);
      #1;

      issue(13, 1, 0, 32'h0000_0010, 32'h0,        1,  32'h0000_0009, 32'h0000_0009, 0, 2);
      idle(3);

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
